// File: rtl/reg_file_pkg.sv
// Shared defaults, word typedefs and the write-port priority helper for the
// multi-ported register file (REG_BYPASS_EN selects write-through forwarding).
package reg_file_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 5;
   localparam int DEF_NUM_RD = 2;
   localparam int DEF_NUM_WR = 2;
   localparam int MAX_PORTS  = 16;

   typedef logic [DEF_ADDR_W-1:0] addr_t;
   typedef logic [DEF_DATA_W-1:0] data_t;

   // Highest-index set bit wins; -1 when no port hits.
   function automatic int prio_sel(input logic [MAX_PORTS-1:0] hit);
      int sel;
      sel = -1;
      for (int i = 0; i < MAX_PORTS; i++) begin
         if (hit[i]) sel = i;
      end
      return sel;
   endfunction

endpackage

// File: rtl/reg_file_sb.sv
// Busy scoreboard: per-entry pending-producer bits, registered popcount and
// per-read-port busy lookup (post-edge view when REG_BYPASS_EN is defined).
module reg_file_sb
   import reg_file_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int NUM_RD   = DEF_NUM_RD,
   parameter int NUM_WR   = DEF_NUM_WR,
   parameter int ZERO_REG = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_WR-1:0]        wr_en,
   input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
   input  logic                     rsv_en,
   input  logic [ADDR_W-1:0]        rsv_addr,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD-1:0]        rd_busy,
   output logic [ADDR_W:0]          busy_cnt
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DEPTH-1:0] busy_q;
   logic [DEPTH-1:0] busy_nxt;
   logic [ADDR_W:0]  cnt_nxt;
   logic [ADDR_W-1:0] ra;

   // Writes retire a producer; a same-cycle reservation is a newer producer and wins.
   always_comb begin
      busy_nxt = busy_q;
      for (int w = 0; w < NUM_WR; w++) begin
         if (wr_en[w]) busy_nxt[wr_addr[w*ADDR_W +: ADDR_W]] = 1'b0;
      end
      if (rsv_en) busy_nxt[rsv_addr] = 1'b1;
      if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
      cnt_nxt = '0;
      for (int i = 0; i < DEPTH; i++) begin
         cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, busy_nxt[i]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q   <= '0;
         busy_cnt <= '0;
      end else begin
         busy_q   <= busy_nxt;
         busy_cnt <= cnt_nxt;
      end
   end

   always_comb begin
      ra      = '0;
      rd_busy = '0;
      for (int r = 0; r < NUM_RD; r++) begin
         ra = rd_addr[r*ADDR_W +: ADDR_W];
`ifdef REG_BYPASS_EN
         rd_busy[r] = rst_n & busy_nxt[ra];
`else
         rd_busy[r] = busy_q[ra];
`endif
      end
   end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-ported register file with fixed-priority write-back ports and busy
// scoreboard; define REG_BYPASS_EN for same-cycle write-to-read forwarding.
module reg_file_mp
   import reg_file_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int NUM_RD   = DEF_NUM_RD,
   parameter int NUM_WR   = DEF_NUM_WR,
   parameter int ZERO_REG = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_RD*ADDR_W-1:0] REG_rd_addr,
   output logic [NUM_RD*DATA_W-1:0] REG_rd_data,
   output logic [NUM_RD-1:0]        REG_rd_busy,
   input  logic [NUM_WR-1:0]        REG_wr_en,
   input  logic [NUM_WR*ADDR_W-1:0] REG_wr_addr,
   input  logic [NUM_WR*DATA_W-1:0] REG_wr_data,
   input  logic                     REG_rsv_en,
   input  logic [ADDR_W-1:0]        REG_rsv_addr,
   output logic [ADDR_W:0]          REG_busy_cnt
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] ra;
   logic [DATA_W-1:0] rd_word;
`ifdef REG_BYPASS_EN
   logic [MAX_PORTS-1:0] hit;
   int                   sel;
`endif

   // Ports are applied in ascending order so the highest-index port owns a conflicting entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         for (int w = 0; w < NUM_WR; w++) begin
            if (REG_wr_en[w] &&
                !(ZERO_REG != 0 && REG_wr_addr[w*ADDR_W +: ADDR_W] == '0))
               mem[REG_wr_addr[w*ADDR_W +: ADDR_W]] <= REG_wr_data[w*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      ra          = '0;
      rd_word     = '0;
      REG_rd_data = '0;
`ifdef REG_BYPASS_EN
      hit = '0;
      sel = -1;
`endif
      for (int r = 0; r < NUM_RD; r++) begin
         ra      = REG_rd_addr[r*ADDR_W +: ADDR_W];
         rd_word = mem[ra];
`ifdef REG_BYPASS_EN
         hit = '0;
         for (int w = 0; w < NUM_WR; w++) begin
            hit[w] = REG_wr_en[w] && (REG_wr_addr[w*ADDR_W +: ADDR_W] == ra);
         end
         sel = prio_sel(hit);
         if (sel >= 0) rd_word = REG_wr_data[sel*DATA_W +: DATA_W];
`endif
         if (!rst_n || (ZERO_REG != 0 && ra == '0)) rd_word = '0;
         REG_rd_data[r*DATA_W +: DATA_W] = rd_word;
      end
   end

   reg_file_sb #(
      .ADDR_W   (ADDR_W),
      .NUM_RD   (NUM_RD),
      .NUM_WR   (NUM_WR),
      .ZERO_REG (ZERO_REG)
   ) u_sb (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (REG_wr_en),
      .wr_addr  (REG_wr_addr),
      .rsv_en   (REG_rsv_en),
      .rsv_addr (REG_rsv_addr),
      .rd_addr  (REG_rd_addr),
      .rd_busy  (REG_rd_busy),
      .busy_cnt (REG_busy_cnt)
   );

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: default 32x32/2R2W instance plus a 64x64/4R3W
// sweep instance; expectations follow REG_BYPASS_EN when it is defined.
module tb_reg_file_mp;

`ifdef REG_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [9:0]  rd_addr;
   logic [63:0] rd_data;
   logic [1:0]  rd_busy;
   logic [1:0]  wr_en;
   logic [9:0]  wr_addr;
   logic [63:0] wr_data;
   logic        rsv_en;
   logic [4:0]  rsv_addr;
   logic [5:0]  busy_cnt;

   logic [23:0]  w_rd_addr;
   logic [255:0] w_rd_data;
   logic [3:0]   w_rd_busy;
   logic [2:0]   w_wr_en;
   logic [17:0]  w_wr_addr;
   logic [191:0] w_wr_data;
   logic         w_rsv_en;
   logic [5:0]   w_rsv_addr;
   logic [6:0]   w_busy_cnt;

   reg_file_mp dut (
      .clk(clk), .rst_n(rst_n),
      .REG_rd_addr(rd_addr), .REG_rd_data(rd_data), .REG_rd_busy(rd_busy),
      .REG_wr_en(wr_en), .REG_wr_addr(wr_addr), .REG_wr_data(wr_data),
      .REG_rsv_en(rsv_en), .REG_rsv_addr(rsv_addr), .REG_busy_cnt(busy_cnt)
   );

   reg_file_mp #(.DATA_W(64), .ADDR_W(6), .NUM_RD(4), .NUM_WR(3), .ZERO_REG(1)) dut_w (
      .clk(clk), .rst_n(rst_n),
      .REG_rd_addr(w_rd_addr), .REG_rd_data(w_rd_data), .REG_rd_busy(w_rd_busy),
      .REG_wr_en(w_wr_en), .REG_wr_addr(w_wr_addr), .REG_wr_data(w_wr_data),
      .REG_rsv_en(w_rsv_en), .REG_rsv_addr(w_rsv_addr), .REG_busy_cnt(w_busy_cnt)
   );

   typedef struct {
      string       tag;
      logic [63:0] val;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   failures = 0;

   task automatic push(input string tag, input logic [63:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      sbq.push_back(e);
   endtask

   task automatic chk(input logic [63:0] obs);
      exp_t e;
      checks++;
      if (sbq.size() == 0) begin
         failures++;
         $error("FAIL scoreboard_empty observed=%h required=<queued value>", obs);
      end else begin
         e = sbq.pop_front();
         assert (obs === e.val) else begin
            failures++;
            $error("FAIL %s observed=%h required=%h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] wpat(input int a);
      return 64'hC0DE_0000_0000_0000 ^ (64'(a) * 64'h0001_0001_0001_0001);
   endfunction

   initial begin
      rst_n = 1'b0;
      rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0; rsv_en = 1'b0; rsv_addr = '0;
      w_rd_addr = '0; w_wr_en = '0; w_wr_addr = '0; w_wr_data = '0; w_rsv_en = 1'b0; w_rsv_addr = '0;
      #2;
      push("reset_cnt", 64'd0);   chk(64'(busy_cnt));
      push("reset_rd", 64'd0);    chk(64'(rd_data[31:0]));
      push("reset_busy", 64'd0);  chk(64'(rd_busy));
      tick();
      rst_n = 1'b1;
      tick();

      // Write/read and same-cycle visibility
      wr_en = 2'b01; wr_addr[4:0] = 5'd3; wr_data[31:0] = 32'h1234_5678;
      rd_addr = {5'd3, 5'd3};
      #1;
      push("same_cycle_rd", BYP ? 64'h1234_5678 : 64'd0); chk(64'(rd_data[31:0]));
      tick();
      wr_en = '0;
      #1;
      push("rd_p0_r3", 64'h1234_5678); chk(64'(rd_data[31:0]));
      push("rd_p1_r3", 64'h1234_5678); chk(64'(rd_data[63:32]));

      // Write-port priority
      wr_en = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {32'h0000_BBBB, 32'h0000_AAAA};
      rd_addr = {5'd7, 5'd7};
      #1;
      push("prio_same_cycle", BYP ? 64'h0000_BBBB : 64'd0); chk(64'(rd_data[31:0]));
      tick();
      wr_en = '0;
      #1;
      push("prio_r7", 64'h0000_BBBB); chk(64'(rd_data[31:0]));

      // Scoreboard reserve / clear
      rsv_en = 1'b1; rsv_addr = 5'd9; rd_addr = {5'd9, 5'd9};
      #1;
      push("rsv_same_cycle_busy", 64'(BYP)); chk(64'(rd_busy[0]));
      tick();
      rsv_en = 1'b0;
      #1;
      push("rsv_busy_p0", 64'd1); chk(64'(rd_busy[0]));
      push("rsv_busy_p1", 64'd1); chk(64'(rd_busy[1]));
      push("rsv_cnt", 64'd1);     chk(64'(busy_cnt));
      rsv_en = 1'b1; rsv_addr = 5'd9;
      tick();
      rsv_en = 1'b0;
      #1;
      push("rersv_cnt", 64'd1); chk(64'(busy_cnt));
      wr_en = 2'b01; wr_addr[4:0] = 5'd9; wr_data[31:0] = 32'h0000_0099;
      #1;
      push("clr_same_cycle_busy", BYP ? 64'd0 : 64'd1); chk(64'(rd_busy[0]));
      tick();
      wr_en = '0;
      #1;
      push("clr_busy", 64'd0);      chk(64'(rd_busy[0]));
      push("clr_cnt", 64'd0);       chk(64'(busy_cnt));
      push("clr_data", 64'h99);     chk(64'(rd_data[31:0]));
      wr_en = 2'b01; wr_addr[4:0] = 5'd9; wr_data[31:0] = 32'h0000_0055;
      rsv_en = 1'b1; rsv_addr = 5'd9;
      #1;
      push("rsvwr_same_cycle_busy", 64'(BYP)); chk(64'(rd_busy[0]));
      push("rsvwr_same_cycle_rd", BYP ? 64'h55 : 64'h99); chk(64'(rd_data[31:0]));
      tick();
      wr_en = '0; rsv_en = 1'b0;
      #1;
      push("rsvwr_busy", 64'd1); chk(64'(rd_busy[0]));
      push("rsvwr_data", 64'h55); chk(64'(rd_data[31:0]));
      push("rsvwr_cnt", 64'd1);  chk(64'(busy_cnt));

      // Zero register
      wr_en = 2'b01; wr_addr[4:0] = 5'd0; wr_data[31:0] = 32'hFFFF_FFFF;
      rsv_en = 1'b1; rsv_addr = 5'd0; rd_addr = {5'd0, 5'd0};
      #1;
      push("zero_same_cycle_rd", 64'd0);   chk(64'(rd_data[31:0]));
      push("zero_same_cycle_busy", 64'd0); chk(64'(rd_busy[0]));
      tick();
      wr_en = '0; rsv_en = 1'b0;
      #1;
      push("zero_rd", 64'd0);   chk(64'(rd_data[63:32]));
      push("zero_busy", 64'd0); chk(64'(rd_busy[1]));
      push("zero_cnt", 64'd1);  chk(64'(busy_cnt));

      // Asynchronous reset mid-cycle
      wr_en = 2'b01; wr_addr[4:0] = 5'd5; wr_data[31:0] = 32'hDEAD_BEEF;
      rsv_en = 1'b1; rsv_addr = 5'd6;
      tick();
      wr_en = '0; rsv_en = 1'b0; rd_addr = {5'd6, 5'd5};
      #1;
      push("pre_rst_r5", 64'hDEAD_BEEF); chk(64'(rd_data[31:0]));
      push("pre_rst_r6_busy", 64'd1);    chk(64'(rd_busy[1]));
      push("pre_rst_cnt", 64'd2);        chk(64'(busy_cnt));
      wr_en = 2'b01; wr_addr[4:0] = 5'd5; wr_data[31:0] = 32'h1111_1111;
      rsv_en = 1'b1; rsv_addr = 5'd6;
      #2;
      rst_n = 1'b0;
      #1;
      push("rst_r5", 64'd0);      chk(64'(rd_data[31:0]));
      push("rst_r6_busy", 64'd0); chk(64'(rd_busy[1]));
      push("rst_cnt", 64'd0);     chk(64'(busy_cnt));
      tick();
      wr_en = '0; rsv_en = 1'b0;
      rst_n = 1'b1;
      rd_addr = {5'd3, 5'd5};
      #1;
      push("post_rst_r5", 64'd0);  chk(64'(rd_data[31:0]));
      push("post_rst_r3", 64'd0);  chk(64'(rd_data[63:32]));
      push("post_rst_cnt", 64'd0); chk(64'(busy_cnt));
      tick();

      // Wide configuration sweep
      for (int i = 0; i < 64; i += 3) begin
         for (int p = 0; p < 3; p++) begin
            if (i + p < 64) begin
               w_wr_en[p] = 1'b1;
               w_wr_addr[p*6 +: 6] = 6'(i + p);
               w_wr_data[p*64 +: 64] = wpat(i + p);
            end else begin
               w_wr_en[p] = 1'b0;
            end
         end
         tick();
      end
      w_wr_en = '0;
      for (int i = 1; i < 64; i++) begin
         w_rsv_en = 1'b1;
         w_rsv_addr = 6'(i);
         tick();
      end
      w_rsv_en = 1'b0;
      #1;
      push("sweep_cnt", 64'd63); chk(64'(w_busy_cnt));
      for (int i = 0; i < 64; i += 4) begin
         for (int p = 0; p < 4; p++) w_rd_addr[p*6 +: 6] = 6'(i + p);
         #1;
         for (int p = 0; p < 4; p++) begin
            push($sformatf("sweep_rd_%0d", i + p), (i + p == 0) ? 64'd0 : wpat(i + p));
            chk(w_rd_data[p*64 +: 64]);
            push($sformatf("sweep_busy_%0d", i + p), (i + p == 0) ? 64'd0 : 64'd1);
            chk(64'(w_rd_busy[p]));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
